// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped machine timer on the clk24 data bus.
// Holds a prescaled mtime counter and up to 8 compare channels with
// per-channel interrupt enables. A shadow latch makes LO-then-HI reads of
// mtime atomic. Read data and hit are registered (one cycle latency).
module mmio_timer #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h80000000,
  parameter int unsigned NUM_COMPARATORS = 2,
  parameter int unsigned TIMER_WIDTH     = 64,
  parameter int unsigned PRESCALE_WIDTH  = 8
) (
  input  logic                       clk24,
  input  logic                       reset,
  input  logic [31:0]                memory_address,
  input  logic                       read_enable,
  input  logic [31:0]                memory_write_value,
  input  logic [3:0]                 memory_write_sections,
  output logic [31:0]                read_value,
  output logic                       read_hit,
  output logic [NUM_COMPARATORS-1:0] timer_interrupt
);

  localparam int unsigned HiWidth = TIMER_WIDTH - 32;
  // First word index past the last implemented compare register.
  localparam logic [29:0] WordEnd = 30'(8 + 2 * NUM_COMPARATORS);

  typedef logic [TIMER_WIDTH-1:0] timer_t;

  timer_t                     mtime_q, mtime_d;
  timer_t                     cmp_q [NUM_COMPARATORS];
  timer_t                     cmp_d [NUM_COMPARATORS];
  logic [PRESCALE_WIDTH-1:0]  presc_q, presc_d;
  logic [PRESCALE_WIDTH-1:0]  div_q, div_d;
  logic                       en_q, en_d;
  logic [NUM_COMPARATORS-1:0] ie_q, ie_d;
  logic [NUM_COMPARATORS-1:0] status;
  logic [NUM_COMPARATORS-1:0] irq_q;
  logic [HiWidth-1:0]         shadow_q, shadow_d;
  logic [31:0]                rdata, read_value_q;
  logic                       read_hit_q;
  logic [31:0]                ctrl_rd, ctrl_m, ie_m;

  logic [29:0] word_idx;
  logic        hit, wr, rd;
  logic        unused_addr, unused_ctrl, unused_ie;

  // Byte offsets within a word are carried by the lane enables, not the address.
  assign word_idx    = memory_address[31:2] - BASE_ADDRESS[31:2];
  assign unused_addr = ^memory_address[1:0];
  assign unused_ctrl = ^ctrl_m;
  assign unused_ie   = ^ie_m;
  assign hit = (word_idx < 30'd5) || ((word_idx >= 30'd8) && (word_idx < WordEnd));
  assign wr  = hit && (memory_write_sections != 4'b0000);
  assign rd  = hit && read_enable;

  function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    end
    return res;
  endfunction

  // Bits above TIMER_WIDTH are dropped, so writes to them are ignored.
  function automatic timer_t merge_timer(input timer_t old, input logic hi,
                                         input logic [31:0] wdata, input logic [3:0] be);
    logic [63:0] ext;
    ext = 64'(old);
    if (hi) ext[63:32] = merge32(ext[63:32], wdata, be);
    else    ext[31:0]  = merge32(ext[31:0], wdata, be);
    return ext[TIMER_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] timer_word(input timer_t v, input logic hi);
    logic [63:0] ext;
    ext = 64'(v);
    return hi ? ext[63:32] : ext[31:0];
  endfunction

  // Per-channel unsigned full-width compare.
  always_comb begin
    status = '0;
    for (int i = 0; i < NUM_COMPARATORS; i++) begin
      status[i] = (mtime_q >= cmp_q[i]);
    end
  end

  // CONTROL read image and byte-merged write images.
  always_comb begin
    ctrl_rd                     = '0;
    ctrl_rd[0]                  = en_q;
    ctrl_rd[8 +: PRESCALE_WIDTH] = div_q;
    ctrl_m = merge32(ctrl_rd, memory_write_value, memory_write_sections);
    ie_m   = merge32(32'(ie_q), memory_write_value, memory_write_sections);
  end

  // Next-state: counting, register writes and shadow capture.
  always_comb begin
    mtime_d  = mtime_q;
    presc_d  = presc_q;
    en_d     = en_q;
    div_d    = div_q;
    ie_d     = ie_q;
    cmp_d    = cmp_q;
    shadow_d = shadow_q;

    if (en_q) begin
      if (presc_q == div_q) begin
        presc_d = '0;
        mtime_d = mtime_q + timer_t'(1);
      end else begin
        // Past a lowered divisor this wraps at the counter width before ticking.
        presc_d = presc_q + PRESCALE_WIDTH'(1);
      end
    end

    // A software write to mtime overrides the tick and restarts the prescaler.
    if (wr && (word_idx <= 30'd1)) begin
      mtime_d = merge_timer(mtime_q, word_idx[0], memory_write_value, memory_write_sections);
      presc_d = '0;
    end

    if (wr && (word_idx == 30'd2)) begin
      en_d  = ctrl_m[0];
      div_d = ctrl_m[8 +: PRESCALE_WIDTH];
    end

    if (wr && (word_idx == 30'd3)) begin
      ie_d = ie_m[NUM_COMPARATORS-1:0];
    end

    for (int i = 0; i < NUM_COMPARATORS; i++) begin
      if (wr && (word_idx >= 30'd8) && (((word_idx - 30'd8) >> 1) == 30'(i))) begin
        cmp_d[i] = merge_timer(cmp_q[i], word_idx[0], memory_write_value,
                               memory_write_sections);
      end
    end

    if (rd && (word_idx == 30'd0)) begin
      shadow_d = mtime_q[TIMER_WIDTH-1:32];
    end
  end

  // Read mux over pre-write state.
  always_comb begin
    rdata = '0;
    case (word_idx)
      30'd0:   rdata = timer_word(mtime_q, 1'b0);
      30'd1:   rdata = 32'(shadow_q);
      30'd2:   rdata = ctrl_rd;
      30'd3:   rdata = 32'(ie_q);
      30'd4:   rdata = 32'(status);
      default: begin
        for (int i = 0; i < NUM_COMPARATORS; i++) begin
          if ((word_idx >= 30'd8) && (((word_idx - 30'd8) >> 1) == 30'(i))) begin
            rdata = timer_word(cmp_q[i], word_idx[0]);
          end
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      mtime_q      <= '0;
      presc_q      <= '0;
      en_q         <= 1'b1;
      div_q        <= '0;
      ie_q         <= '0;
      shadow_q     <= '0;
      irq_q        <= '0;
      read_value_q <= '0;
      read_hit_q   <= 1'b0;
      for (int i = 0; i < NUM_COMPARATORS; i++) begin
        cmp_q[i] <= '1;
      end
    end else begin
      mtime_q      <= mtime_d;
      presc_q      <= presc_d;
      en_q         <= en_d;
      div_q        <= div_d;
      ie_q         <= ie_d;
      shadow_q     <= shadow_d;
      irq_q        <= status & ie_q;
      read_value_q <= rd ? rdata : '0;
      read_hit_q   <= rd;
      for (int i = 0; i < NUM_COMPARATORS; i++) begin
        cmp_q[i] <= cmp_d[i];
      end
    end
  end

  assign read_value      = read_value_q;
  assign read_hit        = read_hit_q;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed scenarios plus randomized bus traffic, every cycle
// checked against a behavioural model of the register map.
module tb_mmio_timer;

  localparam logic [31:0] Base = 32'h80000000;

  logic        clk24 = 1'b0;
  logic        reset;
  logic [31:0] memory_address;
  logic        read_enable;
  logic [31:0] memory_write_value;
  logic [3:0]  memory_write_sections;
  logic [31:0] read_value;
  logic        read_hit;
  logic [1:0]  timer_interrupt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mmio_timer #(
    .BASE_ADDRESS   (Base),
    .NUM_COMPARATORS(2),
    .TIMER_WIDTH    (64),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk24                (clk24),
    .reset                (reset),
    .memory_address       (memory_address),
    .read_enable          (read_enable),
    .memory_write_value   (memory_write_value),
    .memory_write_sections(memory_write_sections),
    .read_value           (read_value),
    .read_hit             (read_hit),
    .timer_interrupt      (timer_interrupt)
  );

  always #5 clk24 = ~clk24;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model of the register map.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [2];
  logic [31:0] m_shadow;
  int unsigned m_presc, m_div;
  bit          m_en;
  logic [1:0]  m_ie;
  logic [31:0] e_rv;
  bit          e_rh;
  logic [1:0]  e_irq;

  task automatic m_reset();
    m_mtime  = 64'h0;
    m_cmp[0] = '1;
    m_cmp[1] = '1;
    m_shadow = 32'h0;
    m_presc  = 0;
    m_div    = 0;
    m_en     = 1'b1;
    m_ie     = 2'b00;
    e_rv     = 32'h0;
    e_rh     = 1'b0;
    e_irq    = 2'b00;
  endtask

  function automatic bit m_hit(input int unsigned w);
    return (w < 5) || (w >= 8 && w < 12);
  endfunction

  function automatic logic [1:0] m_status();
    logic [1:0] s;
    for (int i = 0; i < 2; i++) s[i] = (m_mtime >= m_cmp[i]);
    return s;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int unsigned w);
    logic [63:0] c;
    case (w)
      0: return m_mtime[31:0];
      1: return m_shadow;
      2: return {16'h0, 8'(m_div), 7'h0, m_en};
      3: return {30'h0, m_ie};
      4: return {30'h0, m_status()};
      default: begin
        c = m_cmp[(w - 8) / 2];
        return (w % 2 == 1) ? c[63:32] : c[31:0];
      end
    endcase
  endfunction

  // Advance the model by one clock edge with the given bus request.
  task automatic m_step(input logic [31:0] addr, input bit re, input logic [31:0] wd,
                        input logic [3:0] be);
    logic [31:0] off, tmp;
    int unsigned w, nxt_presc;
    bit          hit;
    logic [63:0] nxt_mtime, c;
    off   = addr - Base;
    w     = off >> 2;
    hit   = m_hit(w);
    e_rh  = re && hit;
    e_rv  = e_rh ? m_read(w) : 32'h0;
    e_irq = m_status() & m_ie;
    if (e_rh && w == 0) m_shadow = m_mtime[63:32];
    nxt_mtime = m_mtime;
    nxt_presc = m_presc;
    if (m_en) begin
      if (m_presc == m_div) begin
        nxt_presc = 0;
        nxt_mtime = m_mtime + 64'd1;
      end else begin
        nxt_presc = (m_presc + 1) % 256;
      end
    end
    if (hit && be != 4'h0) begin
      case (w)
        0: begin
          nxt_mtime = {m_mtime[63:32], bmerge(m_mtime[31:0], wd, be)};
          nxt_presc = 0;
        end
        1: begin
          nxt_mtime = {bmerge(m_mtime[63:32], wd, be), m_mtime[31:0]};
          nxt_presc = 0;
        end
        2: begin
          tmp   = bmerge({16'h0, 8'(m_div), 7'h0, m_en}, wd, be);
          m_en  = tmp[0];
          m_div = int'(tmp[15:8]);
        end
        3: begin
          tmp  = bmerge({30'h0, m_ie}, wd, be);
          m_ie = tmp[1:0];
        end
        4: ;
        default: begin
          c = m_cmp[(w - 8) / 2];
          if (w % 2 == 1) c[63:32] = bmerge(c[63:32], wd, be);
          else            c[31:0]  = bmerge(c[31:0], wd, be);
          m_cmp[(w - 8) / 2] = c;
        end
      endcase
    end
    m_mtime = nxt_mtime;
    m_presc = nxt_presc;
  endtask

  // One bus cycle: drive, clock, step model, compare all outputs.
  task automatic bus(input logic [31:0] addr, input bit re, input logic [31:0] wd,
                     input logic [3:0] be);
    memory_address        = addr;
    read_enable           = re;
    memory_write_value    = wd;
    memory_write_sections = be;
    @(posedge clk24);
    m_step(addr, re, wd, be);
    #1;
    check("read_value", read_value, e_rv);
    check("read_hit", read_hit, e_rh);
    check("timer_interrupt", timer_interrupt, e_irq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(32'h0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic wr32(input logic [31:0] off, input logic [31:0] data);
    bus(Base + off, 1'b0, data, 4'hF);
  endtask

  task automatic rd32(input logic [31:0] off);
    bus(Base + off, 1'b1, 32'h0, 4'h0);
  endtask

  logic [31:0] offs [14] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h1C,
                             32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h40, 32'h100};

  initial begin
    logic [63:0] frozen;
    logic [31:0] off, wd;
    logic [3:0]  be;
    bit          re;

    reset                 = 1'b1;
    memory_address        = 32'h0;
    read_enable           = 1'b0;
    memory_write_value    = 32'h0;
    memory_write_sections = 4'h0;
    m_reset();
    #7;
    check("reset_read_value", read_value, 32'h0);
    check("reset_read_hit", read_hit, 1'b0);
    check("reset_irq", timer_interrupt, 2'b00);
    #10;
    reset = 1'b0;

    // Divisor 0 after reset: mtime equals the number of elapsed edges.
    idle(7);
    rd32(32'h0);
    check("lo_after_reset", read_value, 32'd7);
    check("hit_after_reset", read_hit, 1'b1);

    // Divisor 3: one increment per four cycles.
    wr32(32'h8, 32'h301);
    wr32(32'h4, 32'h0);
    wr32(32'h0, 32'h0);
    for (int j = 1; j <= 12; j++) begin
      rd32(32'h0);
      check("div3_rate", read_value, 32'((j - 1) / 4));
    end
    wr32(32'h8, 32'h300);
    frozen = m_mtime;
    idle(100);
    rd32(32'h0);
    check("frozen_mtime", read_value, frozen[31:0]);

    // Atomic read across the 32-bit carry.
    wr32(32'h8, 32'h1);
    wr32(32'h4, 32'h0);
    wr32(32'h0, 32'hFFFF_FFFE);
    rd32(32'h0);
    check("shadow_lo", read_value, 32'hFFFF_FFFE);
    idle(10);
    rd32(32'h4);
    check("shadow_hi", read_value, 32'h0);
    rd32(32'h0);
    rd32(32'h4);
    check("live_hi", read_value, 32'h1);

    // Channel 1 compare at 50.
    wr32(32'h28, 32'd50);
    wr32(32'h2C, 32'h0);
    wr32(32'h4, 32'h0);
    wr32(32'h0, 32'h0);
    wr32(32'hC, 32'h2);
    for (int k = 2; k <= 55; k++) begin
      idle(1);
      check("irq1_rise", timer_interrupt[1], k >= 51);
      check("irq0_low", timer_interrupt[0], 1'b0);
    end
    wr32(32'h2C, 32'hFFFF_FFFF);
    check("irq1_hold", timer_interrupt[1], 1'b1);
    wr32(32'h28, 32'hFFFF_FFFF);
    check("irq1_drop", timer_interrupt[1], 1'b0);

    // Single byte lane into mtime[47:40] while counting.
    wr32(32'h4, 32'h1122_3344);
    wr32(32'h0, 32'h0);
    bus(Base + 32'h5, 1'b0, 32'h0000_AB00, 4'b0010);
    rd32(32'h0);
    check("byte_lo", read_value, 32'h0);
    rd32(32'h4);
    check("byte_hi", read_value, 32'h1122_AB44);
    bus(Base + 32'h40, 1'b1, 32'hDEAD_BEEF, 4'hF);
    check("hole_40_hit", read_hit, 1'b0);
    bus(Base + 32'h14, 1'b1, 32'hDEAD_BEEF, 4'hF);
    check("hole_14_hit", read_hit, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      off = offs[$urandom_range(0, 13)] + 32'($urandom_range(0, 3));
      re  = 1'($urandom_range(0, 1));
      be  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      wd  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : 32'($urandom);
      if (off[31:2] == 30'd2) begin
        wd = {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 7) != 0)};
      end
      bus(Base + off, re, wd, be);
    end

    // Asynchronous reset mid-count with an interrupt active.
    wr32(32'h8, 32'h1);
    wr32(32'h20, 32'h0);
    wr32(32'h24, 32'h0);
    wr32(32'hC, 32'h3);
    idle(2);
    check("irq0_pre_reset", timer_interrupt[0], 1'b1);
    rd32(32'h0);
    check("hit_pre_reset", read_hit, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_read_value", read_value, 32'h0);
    check("async_read_hit", read_hit, 1'b0);
    check("async_irq", timer_interrupt, 2'b00);
    m_reset();
    #1;
    reset = 1'b0;
    rd32(32'h4);
    check("reset_shadow", read_value, 32'h0);
    rd32(32'h8);
    check("reset_control", read_value, 32'h1);
    rd32(32'hC);
    check("reset_ie", read_value, 32'h0);
    rd32(32'h20);
    check("reset_cmp0_lo", read_value, 32'hFFFF_FFFF);
    rd32(32'h2C);
    check("reset_cmp1_hi", read_value, 32'hFFFF_FFFF);
    rd32(32'h10);
    check("reset_status", read_value, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
